// File: rtl/imem_loader.sv
// imem_loader: assembles a header-prefixed byte stream into 16-bit words, writes them into
// the instruction RAM from address 0, and holds the CPU in reset until the image is complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [8:0]        DEPTH_B  = 9'(DEPTH);
    localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_ERROR = 3'd6,
        S_CHK   = 3'd7
`else
        S_ERROR = 3'd6
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [15:0]       wdata_r;
    logic [ADDR_W:0]   words_r;
    logic              rx_ready_r;
    logic              we_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              cpu_reset_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    logic accept_s;
    logic hdr_bad_s;
    logic last_word_s;
    logic start_ok_s;
    logic rx_ready_s;
    logic we_s;
    logic busy_s;
    logic done_s;
    logic error_s;
    logic cpu_reset_s;

    // Handshake and decision terms shared by the FSM and the datapath
    always_comb begin
        accept_s    = rx_valid && rx_ready_r;
        hdr_bad_s   = (rx_data == 8'h00) || ({1'b0, rx_data} > DEPTH_B);
        last_word_s = ((words_r + WORD_ONE) == n_r);
        start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERROR));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_HDR;
                else       state_s = S_IDLE;
            end
            S_HDR: begin
                if (accept_s) begin
                    if (hdr_bad_s) state_s = S_ERROR;
                    else           state_s = S_HI;
                end else begin
                    state_s = S_HDR;
                end
            end
            S_HI: begin
                if (accept_s) state_s = S_LO;
                else          state_s = S_HI;
            end
            S_LO: begin
                if (accept_s) state_s = S_WRITE;
                else          state_s = S_LO;
            end
            S_WRITE: begin
                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_s = S_CHK;
`else
                    state_s = S_DONE;
`endif
                end else begin
                    state_s = S_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_s) begin
                    if (rx_data == csum_r) state_s = S_DONE;
                    else                   state_s = S_ERROR;
                end else begin
                    state_s = S_CHK;
                end
            end
`endif
            S_DONE: begin
                if (start) state_s = S_HDR;
                else       state_s = S_DONE;
            end
            S_ERROR: begin
                if (start) state_s = S_HDR;
                else       state_s = S_ERROR;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so every output leaves a flop
    always_comb begin
        rx_ready_s  = 1'b0;
        we_s        = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        error_s     = 1'b0;
        cpu_reset_s = 1'b1;
        case (state_s)
            S_IDLE: begin
                cpu_reset_s = 1'b1;
            end
            S_HDR, S_HI, S_LO: begin
                rx_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            S_WRITE: begin
                we_s   = 1'b1;
                busy_s = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
`endif
            S_DONE: begin
                done_s      = 1'b1;
                cpu_reset_s = 1'b0;
            end
            S_ERROR: begin
                error_s = 1'b1;
            end
            default: begin
                cpu_reset_s = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Registered control outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_r  <= 1'b0;
            we_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            cpu_reset_r <= 1'b1;
        end else begin
            rx_ready_r  <= rx_ready_s;
            we_r        <= we_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            cpu_reset_r <= cpu_reset_s;
        end
    end

    // Word count, address and counters; address advances as the WRITE cycle ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r     <= '0;
            waddr_r <= '0;
            words_r <= '0;
        end else begin
            if (start_ok_s) begin
                waddr_r <= '0;
                words_r <= '0;
            end else if (state_r == S_WRITE) begin
                waddr_r <= waddr_r + ADDR_ONE;
                words_r <= words_r + WORD_ONE;
            end
            if ((state_r == S_HDR) && accept_s && !hdr_bad_s) begin
                n_r <= rx_data[ADDR_W:0];
            end
        end
    end

    // Instruction word assembly, high byte first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdata_r <= 16'h0000;
        end else if (accept_s && (state_r == S_HI)) begin
            wdata_r[15:8] <= rx_data;
        end else if (accept_s && (state_r == S_LO)) begin
            wdata_r[7:0] <= rx_data;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; the header is excluded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r <= 8'h00;
        end else if (start_ok_s) begin
            csum_r <= 8'h00;
        end else if (accept_s && ((state_r == S_HI) || (state_r == S_LO))) begin
            csum_r <= xor_accum(csum_r, rx_data);
        end
    end
`endif

    assign rx_ready     = rx_ready_r;
    assign imem_we      = we_r;
    assign imem_waddr   = waddr_r;
    assign imem_wdata   = wdata_r;
    assign cpu_reset    = cpu_reset_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_r;

endmodule
